// File: rtl/sequenced_control_unit_pkg.sv
// Shared definitions for the sequenced control unit: instruction field
// encodings, ALU command encodings, FSM states and the decode function.
package sequenced_control_unit_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Instruction mode field
    localparam logic [1:0] MODE_ARITH  = 2'b00;
    localparam logic [1:0] MODE_MEM    = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;

    // Arithmetic opcodes
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_TST = 4'b1000;

    // In memory mode the S bit is the L bit: 1 = load, 0 = store
    localparam logic S_LDR = 1'b1;
    localparam logic S_STR = 1'b0;

    // instr[7:4] pattern that turns AND into MUL
    localparam logic [3:0] MUL_PATTERN = 4'b1001;

    // Execute-stage ALU commands
    localparam logic [3:0] NOP_EXE = 4'b0000;
    localparam logic [3:0] MOV_EXE = 4'b0001;
    localparam logic [3:0] MVN_EXE = 4'b1001;
    localparam logic [3:0] ADD_EXE = 4'b0010;
    localparam logic [3:0] ADC_EXE = 4'b0011;
    localparam logic [3:0] SUB_EXE = 4'b0100;
    localparam logic [3:0] SBC_EXE = 4'b0101;
    localparam logic [3:0] AND_EXE = 4'b0110;
    localparam logic [3:0] ORR_EXE = 4'b0111;
    localparam logic [3:0] EOR_EXE = 4'b1000;
    localparam logic [3:0] CMP_EXE = 4'b0100;
    localparam logic [3:0] TST_EXE = 4'b0110;
    localparam logic [3:0] MUL_EXE = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_BLOCK    = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] cmd;
        logic       mem_read;
        logic       mem_write;
        logic       wb_enable;
        logic       immediate;
        logic       branch_taken;
        logic       status_write_enable;
        logic       ignore_hazard;
        logic       is_mul;
        logic       ctrl_valid;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Undefined encodings still occupy a slot in EXE, but do nothing there
    function automatic ctrl_t ctrl_undefined();
        ctrl_t c;
        c = CTRL_BUBBLE;
        c.ctrl_valid = ENABLE;
        return c;
    endfunction

    // One micro-op of an LDM/STM block transfer
    function automatic ctrl_t xfer_op(input logic load, input logic imm);
        ctrl_t c;
        c = CTRL_BUBBLE;
        c.cmd        = ADD_EXE;
        c.mem_read   = load;
        c.wb_enable  = load;
        c.mem_write  = ~load;
        c.immediate  = imm;
        c.ctrl_valid = ENABLE;
        return c;
    endfunction

    // Single-instruction decode (block transfers are sequenced by the top)
    function automatic ctrl_t decode(input logic [1:0] mode, input logic [3:0] opcode,
                                     input logic s, input logic imm,
                                     input logic [3:0] mul_detector);
        ctrl_t c;
        c = CTRL_BUBBLE;
        c.ctrl_valid = ENABLE;
        c.immediate  = imm;
        case (mode)
            MODE_ARITH: begin
                c.status_write_enable = s;
                case (opcode)
                    OP_MOV: begin c.cmd = MOV_EXE; c.wb_enable = ENABLE; c.ignore_hazard = ENABLE; end
                    OP_MVN: begin c.cmd = MVN_EXE; c.wb_enable = ENABLE; c.ignore_hazard = ENABLE; end
                    OP_ADD: begin c.cmd = ADD_EXE; c.wb_enable = ENABLE; end
                    OP_ADC: begin c.cmd = ADC_EXE; c.wb_enable = ENABLE; end
                    OP_SUB: begin c.cmd = SUB_EXE; c.wb_enable = ENABLE; end
                    OP_SBC: begin c.cmd = SBC_EXE; c.wb_enable = ENABLE; end
                    OP_ORR: begin c.cmd = ORR_EXE; c.wb_enable = ENABLE; end
                    OP_EOR: begin c.cmd = EOR_EXE; c.wb_enable = ENABLE; end
                    OP_AND: begin
                        c.wb_enable = ENABLE;
                        if (mul_detector == MUL_PATTERN && imm == DISABLE) begin
                            c.cmd    = MUL_EXE;
                            c.is_mul = ENABLE;
                        end else begin
                            c.cmd = AND_EXE;
                        end
                    end
                    OP_CMP: c.cmd = CMP_EXE;
                    OP_TST: c.cmd = TST_EXE;
                    default: c = ctrl_undefined();
                endcase
            end
            MODE_MEM: begin
                c.cmd = ADD_EXE;
                if (s == S_LDR) begin
                    c.mem_read  = ENABLE;
                    c.wb_enable = ENABLE;
                end else begin
                    c.mem_write = ENABLE;
                end
            end
            MODE_BRANCH: begin
                c.cmd           = NOP_EXE;
                c.branch_taken  = ENABLE;
                c.ignore_hazard = ENABLE;
            end
            default: c = ctrl_undefined();
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sequenced_control_unit_if.sv
// Decode-side bundle of the sequenced control unit: instruction fields in,
// ID/EX control word and back-pressure out.
interface sequenced_control_unit_if #(
    parameter int REG_LIST_W          = 16,
    parameter int EXECUTE_COMMAND_LEN = 4
);
    logic                              instr_valid;
    logic                              stall;
    logic                              flush;
    logic [1:0]                        mode;
    logic [3:0]                        opcode;
    logic                              s;
    logic                              immediate_in;
    logic [3:0]                        mul_detector;
    logic                              block_transfer;
    logic [REG_LIST_W-1:0]             reg_list;

    logic [EXECUTE_COMMAND_LEN-1:0]    execute_command;
    logic                              mem_read;
    logic                              mem_write;
    logic                              wb_enable;
    logic                              immediate;
    logic                              branch_taken;
    logic                              status_write_enable;
    logic                              ignore_hazard;
    logic                              is_mul;
    logic                              ctrl_valid;
    logic [$clog2(REG_LIST_W)-1:0]     seq_reg_idx;
    logic [$clog2(REG_LIST_W)+1:0]     seq_offset;
    logic                              busy;

    // Decode stage / pipeline side
    modport master (
        output instr_valid, stall, flush, mode, opcode, s, immediate_in,
               mul_detector, block_transfer, reg_list,
        input  execute_command, mem_read, mem_write, wb_enable, immediate,
               branch_taken, status_write_enable, ignore_hazard, is_mul,
               ctrl_valid, seq_reg_idx, seq_offset, busy
    );

    // Control unit side
    modport slave (
        input  instr_valid, stall, flush, mode, opcode, s, immediate_in,
               mul_detector, block_transfer, reg_list,
        output execute_command, mem_read, mem_write, wb_enable, immediate,
               branch_taken, status_write_enable, ignore_hazard, is_mul,
               ctrl_valid, seq_reg_idx, seq_offset, busy
    );
endinterface

// File: rtl/sequenced_control_unit_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of vec, with a flag for an
// all-zero vector.
module lowest_set_bit #(
    parameter int REG_LIST_W = 16
) (
    input  logic [REG_LIST_W-1:0]         vec,
    output logic [$clog2(REG_LIST_W)-1:0] idx,
    output logic                          none
);
    localparam int IDX_W = $clog2(REG_LIST_W);

    logic [REG_LIST_W:0]   lower_empty;
    logic [REG_LIST_W-1:0] first;

    assign lower_empty[0] = 1'b1;

    // Ripple "nothing below me is set" upward; exactly one bit of first is hot
    genvar gi;
    generate
        for (gi = 0; gi < REG_LIST_W; gi++) begin : g_chain
            assign first[gi]           = vec[gi] & lower_empty[gi];
            assign lower_empty[gi + 1] = lower_empty[gi] & ~vec[gi];
        end
    endgenerate

    assign none = lower_empty[REG_LIST_W];

    // Encode the one-hot position into a binary index
    always_comb begin
        idx = '0;
        for (int i = 0; i < REG_LIST_W; i++) begin
            if (first[i]) idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/sequenced_control_unit.sv
// ID/EX control unit: decodes one instruction per accept into a registered
// control word and sequences multi-cycle MUL and LDM/STM block transfers.
module sequenced_control_unit
    import sequenced_control_unit_pkg::*;
#(
    parameter int MUL_LATENCY         = 4,
    parameter int REG_LIST_W          = 16,
    parameter int EXECUTE_COMMAND_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sequenced_control_unit_if.slave bus
);
    localparam int IDX_W = $clog2(REG_LIST_W);
    localparam int OFF_W = IDX_W + 2;
    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [REG_LIST_W-1:0] list_reg, list_next;
    logic [IDX_W-1:0]      k_reg, k_next;
    logic                  load_reg, load_next;
    logic                  imm_reg, imm_next;
    ctrl_t                 ctrl_reg, ctrl_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [OFF_W-1:0]      off_reg, off_next;

    ctrl_t                 dec;
    ctrl_t                 xfer_word;
    logic                  accept;
    logic                  is_block;
    logic [REG_LIST_W-1:0] lsb_src;
    logic [REG_LIST_W-1:0] list_rest;
    logic [IDX_W-1:0]      lsb_idx;
    logic                  lsb_none;

    assign dec      = decode(bus.mode, bus.opcode, bus.s, bus.immediate_in, bus.mul_detector);
    assign is_block = (bus.mode == MODE_MEM) && bus.block_transfer;
    assign accept   = bus.instr_valid & ~bus.stall & ~bus.flush & (state_reg == ST_IDLE);

    // The first micro-op comes straight from the incoming list; later ones
    // from the latched remainder.
    assign lsb_src   = (state_reg == ST_BLOCK) ? list_reg : bus.reg_list;
    assign list_rest = lsb_src & (lsb_src - REG_LIST_W'(1));
    assign xfer_word = (state_reg == ST_BLOCK) ? xfer_op(load_reg, imm_reg)
                                               : xfer_op(bus.s, bus.immediate_in);

    lowest_set_bit #(.REG_LIST_W(REG_LIST_W)) u_lsb (
        .vec  (lsb_src),
        .idx  (lsb_idx),
        .none (lsb_none)
    );

    // Next-state: sequence MUL latency and block-transfer register walk
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        list_next  = list_reg;
        k_next     = k_reg;
        load_next  = load_reg;
        imm_next   = imm_reg;
        if (bus.flush) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            list_next  = '0;
            k_next     = '0;
        end else if (!bus.stall) begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_block) begin
                            list_next = list_rest;
                            load_next = bus.s;
                            imm_next  = bus.immediate_in;
                            if (list_rest != '0) begin
                                state_next = ST_BLOCK;
                                k_next     = IDX_W'(1);
                            end
                        end else if (dec.is_mul && MUL_LATENCY > 1) begin
                            state_next = ST_MUL_WAIT;
                            cnt_next   = CNT_W'(MUL_LATENCY - 1);
                        end
                    end
                end
                ST_MUL_WAIT: begin
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                ST_BLOCK: begin
                    list_next = list_rest;
                    if (list_rest == '0) begin
                        state_next = ST_IDLE;
                        k_next     = '0;
                    end else begin
                        k_next = k_reg + IDX_W'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Output word for the next cycle: decoded word, micro-op or bubble
    always_comb begin
        ctrl_next = ctrl_reg;
        idx_next  = idx_reg;
        off_next  = off_reg;
        if (bus.flush) begin
            ctrl_next = CTRL_BUBBLE;
            idx_next  = '0;
            off_next  = '0;
        end else if (!bus.stall) begin
            ctrl_next = CTRL_BUBBLE;
            idx_next  = '0;
            off_next  = '0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_block) begin
                            // An empty list issues nothing: it stays a bubble
                            if (!lsb_none) begin
                                ctrl_next = xfer_word;
                                idx_next  = lsb_idx;
                            end
                        end else begin
                            ctrl_next = dec;
                        end
                    end
                end
                ST_BLOCK: begin
                    ctrl_next = xfer_word;
                    idx_next  = lsb_idx;
                    off_next  = {k_reg, 2'b00};
                end
                default: ;
            endcase
        end
    end

    // State and output registers; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            list_reg  <= '0;
            k_reg     <= '0;
            load_reg  <= 1'b0;
            imm_reg   <= 1'b0;
            ctrl_reg  <= CTRL_BUBBLE;
            idx_reg   <= '0;
            off_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            list_reg  <= list_next;
            k_reg     <= k_next;
            load_reg  <= load_next;
            imm_reg   <= imm_next;
            ctrl_reg  <= ctrl_next;
            idx_reg   <= idx_next;
            off_reg   <= off_next;
        end
    end

    assign bus.execute_command     = EXECUTE_COMMAND_LEN'(ctrl_reg.cmd);
    assign bus.mem_read            = ctrl_reg.mem_read;
    assign bus.mem_write           = ctrl_reg.mem_write;
    assign bus.wb_enable           = ctrl_reg.wb_enable;
    assign bus.immediate           = ctrl_reg.immediate;
    assign bus.branch_taken        = ctrl_reg.branch_taken;
    assign bus.status_write_enable = ctrl_reg.status_write_enable;
    assign bus.ignore_hazard       = ctrl_reg.ignore_hazard;
    assign bus.is_mul              = ctrl_reg.is_mul;
    assign bus.ctrl_valid          = ctrl_reg.ctrl_valid;
    assign bus.seq_reg_idx         = idx_reg;
    assign bus.seq_offset          = off_reg;
    assign bus.busy                = (state_reg != ST_IDLE);
endmodule
